start_ctrl: RTL and testbench

START_CTRL -- requirements
Module: start_ctrl

---
 rtl/start_ctrl_pkg.sv | 14 +
 rtl/btn_debounce.sv | 58 +++++
 rtl/start_ctrl.sv | 99 +++++++++
 tb/tb_start_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/start_ctrl_pkg.sv
// Shared types and default tuning constants for the start controller.
package start_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HOLDOFF = 2'd2
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_HOLDOFF_CYCLES  = 8;
   localparam int DEF_TIMEOUT_CYCLES  = 64;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, counting debouncer and a
// rising-edge pulse on the debounced level.
module btn_debounce
   import start_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic db,
   output logic trig
);

   localparam logic [7:0] DCNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       db_q, db_d;
   logic       db_dly_q, db_dly_d;
   logic [7:0] dcnt_q, dcnt_d;

   always_comb begin
      s1_d     = btn_in;
      s2_d     = s1_q;
      db_d     = db_q;
      db_dly_d = db_q;
      dcnt_d   = 8'd0;
      // Level change is taken only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (s2_q != db_q) begin
         if (dcnt_q == DCNT_MAX) begin
            db_d = s2_q;
         end else begin
            dcnt_d = dcnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         dcnt_q   <= 8'd0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         db_q     <= db_d;
         db_dly_q <= db_dly_d;
         dcnt_q   <= dcnt_d;
      end
   end

   assign db   = db_q;
   assign trig = db_q & ~db_dly_q;

endmodule

// File: rtl/start_ctrl.sv
// Turns a debounced button press into a start request with done/timeout
// handling, a forced holdoff gap and a saturating trigger counter.
module start_ctrl
   import start_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   input  logic       done,
   output logic       start,
   output logic       busy,
   output logic       timeout_err,
   output logic [7:0] trig_count
);

   localparam logic [15:0] TCNT_MAX = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  HCNT_MAX = 8'(HOLDOFF_CYCLES - 1);

   logic db_unused;
   logic trig;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in),
      .db    (db_unused),
      .trig  (trig)
   );

   state_e      state_q, state_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [7:0]  hcnt_q, hcnt_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      hcnt_d  = hcnt_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = RUN;
               tcnt_d  = 16'd0;
               err_d   = 1'b0;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
         end
         RUN: begin
            tcnt_d = tcnt_q + 16'd1;
            // done has priority over a coincident timeout.
            if (done) begin
               state_d = HOLDOFF;
               hcnt_d  = 8'd0;
            end else if (tcnt_q == TCNT_MAX) begin
               state_d = HOLDOFF;
               hcnt_d  = 8'd0;
               err_d   = 1'b1;
            end
         end
         HOLDOFF: begin
            hcnt_d = hcnt_q + 8'd1;
            if (hcnt_q == HCNT_MAX) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tcnt_q  <= 16'd0;
         hcnt_q  <= 8'd0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         hcnt_q  <= hcnt_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode registered state only.
   assign start       = (state_q == RUN);
   assign busy        = (state_q != IDLE);
   assign timeout_err = err_q;
   assign trig_count  = cnt_q;

endmodule

// File: tb/tb_start_ctrl.sv
// Self-checking bench for start_ctrl: directed scenarios plus randomized
// presses, compared every cycle against a timeline-style reference model.
module tb_start_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 8;
   localparam int TO   = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_in = 1'b0;
   logic       done = 1'b0;
   logic       start;
   logic       busy;
   logic       timeout_err;
   logic [7:0] trig_count;

   always #5 clk = ~clk;

   start_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLDOFF_CYCLES (HOLD),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .done       (done),
      .start      (start),
      .busy       (busy),
      .timeout_err(timeout_err),
      .trig_count (trig_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model. m_hist[i] is btn_in sampled i edges ago; the controller
   // sees a sample two edges late, and a level flips once DEB such delayed
   // samples in a row disagree with it. A run is tracked by its age in
   // cycles (-1 = no run), holdoff by the number of gap cycles left.
   bit m_hist[0:15];
   bit m_db, m_rise, m_err, m_valid;
   int m_run_age = -1;
   int m_hold    = 0;
   int m_cnt     = 0;

   always @(posedge clk) begin : model
      bit trig_now;
      bit all_diff;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_hist[i] = 1'b0;
         m_db = 0; m_rise = 0; m_err = 0; m_cnt = 0;
         m_run_age = -1; m_hold = 0; m_valid = 1;
      end else begin
         trig_now = m_rise;
         if (m_run_age >= 0) begin
            if (done) begin
               m_run_age = -1; m_hold = HOLD;
            end else if (m_run_age == TO - 1) begin
               m_run_age = -1; m_hold = HOLD; m_err = 1;
            end else begin
               m_run_age++;
            end
         end else if (m_hold > 0) begin
            m_hold--;
         end else if (trig_now) begin
            m_run_age = 0; m_err = 0;
            if (m_cnt < 255) m_cnt++;
         end
         for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = btn_in;
         all_diff = 1;
         for (int j = 2; j <= DEB + 1; j++) if (m_hist[j] == m_db) all_diff = 0;
         m_rise = 0;
         if (all_diff) begin
            m_db   = !m_db;
            m_rise = m_db;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("start", int'(start), int'(m_run_age >= 0));
         check("busy", int'(busy), int'(m_run_age >= 0 || m_hold > 0));
         check("timeout_err", int'(timeout_err), int'(m_err));
         check("trig_count", int'(trig_count), m_cnt);
      end
   end

   // Downstream responder: done arrives done_lat cycles into a run (-1 = never);
   // optional noise drives done while no run is active.
   int done_lat   = -1;
   bit done_noise = 0;

   always @(posedge clk) begin
      #1;
      done = (m_run_age >= 0 && m_run_age == done_lat) ||
             (m_run_age < 0 && done_noise && $urandom_range(0, 3) == 0);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((m_run_age >= 0 || m_hold > 0 || m_db || m_rise) && k < 3000) begin
         step(1);
         k++;
      end
      check("idle_reached", int'(k < 3000), 1);
   endtask

   // Press, release after rel_at steps, and return how many cycles start was high.
   task automatic measure_run(input int lat, input int rel_at, output int hi);
      done_lat = lat;
      hi = 0;
      btn_in = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == rel_at) btn_in = 1'b0;
         step(1);
         hi += int'(start);
      end
      btn_in = 1'b0;
   endtask

   initial begin
      int hi;
      bit seen;
      int k;

      rst = 1'b1;
      step(3);
      check("rst_start", int'(start), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(timeout_err), 0);
      check("rst_cnt", int'(trig_count), 0);
      rst = 1'b0;
      step(3);

      // Basic latency and done response.
      done_lat = 10;
      btn_in = 1'b1;
      step(6);
      check("lat_edge5", int'(start), 0);
      step(1);
      check("lat_edge6", int'(start), 1);
      step(10);
      check("before_done", int'(start), 1);
      step(1);
      check("done_fall", int'(start), 0);
      check("done_busy", int'(busy), 1);
      step(7);
      check("holdoff_busy", int'(busy), 1);
      step(1);
      check("holdoff_end", int'(busy), 0);
      btn_in = 1'b0;
      wait_idle();
      check("cnt_one", int'(trig_count), 1);

      // Short glitches never trigger.
      seen = 0;
      for (int w = 1; w <= 3; w++) begin
         btn_in = 1'b1;
         for (int i = 0; i < w; i++) begin step(1); seen |= start; end
         btn_in = 1'b0;
         for (int i = 0; i < 10; i++) begin step(1); seen |= start; end
      end
      check("glitch_start", int'(seen), 0);
      check("glitch_cnt", int'(trig_count), 1);

      // Timeout run, then a completed run clears the error.
      measure_run(-1, 10, hi);
      check("to_len", hi, 64);
      check("to_err", int'(timeout_err), 1);
      wait_idle();
      check("to_err_sticky", int'(timeout_err), 1);
      done_lat = 5;
      btn_in = 1'b1;
      step(7);
      check("err_clear", int'(timeout_err), 0);
      btn_in = 1'b0;
      wait_idle();
      check("cnt_after_to", int'(trig_count), 3);

      // Presses landing in RUN and in HOLDOFF are discarded.
      done_lat = 30;
      btn_in = 1'b1;
      step(7);
      btn_in = 1'b0;
      step(10);
      btn_in = 1'b1;
      step(10);
      btn_in = 1'b0;
      k = 0;
      while (m_hold != HOLD && k < 200) begin step(1); k++; end
      check("holdoff_seen", int'(k < 200), 1);
      btn_in = 1'b1;
      step(8);
      btn_in = 1'b0;
      wait_idle();
      check("ignore_cnt", int'(trig_count), 4);

      // done coincident with the last timeout cycle: done wins.
      measure_run(63, 8, hi);
      check("coin_len", hi, 64);
      check("coin_err", int'(timeout_err), 0);
      wait_idle();
      measure_run(62, 8, hi);
      check("done62_len", hi, 63);
      wait_idle();

      // Reset in RUN cycle 5 with the button still held.
      done_lat = -1;
      btn_in = 1'b1;
      step(7);
      step(5);
      rst = 1'b1;
      step(1);
      check("mid_rst_start", int'(start), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_err", int'(timeout_err), 0);
      check("mid_rst_cnt", int'(trig_count), 0);
      rst = 1'b0;
      step(6);
      check("rel_edge5", int'(start), 0);
      step(1);
      check("rel_edge6", int'(start), 1);
      done_lat = 3;
      btn_in = 1'b0;
      wait_idle();
      check("rst_retrig_cnt", int'(trig_count), 1);

      // Randomized presses, done timing, done noise and occasional resets.
      done_noise = 1;
      for (int it = 0; it < 40; it++) begin
         done_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 70));
         for (int s = 0; s < 6; s++) begin
            btn_in = ~btn_in;
            step($urandom_range(1, 12));
         end
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
         end
         btn_in = 1'b0;
         wait_idle();
      end
      done_noise = 0;

      // Saturation of the trigger counter.
      done_lat = 1;
      for (int n = 0; n < 300; n++) begin
         btn_in = 1'b1;
         step(6);
         btn_in = 1'b0;
         wait_idle();
      end
      check("sat_cnt", int'(trig_count), 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
